// File: rtl/xgs_athena_lite.sv
// xgs_athena_lite: AXI4-Lite register file plus a line DMA engine that writes
// one test-pattern frame to host memory as PCIe MWr TLPs.
// Optional feature macro: XGS_ATHENA_COLOR_PLANES_EN (three planes per frame,
// FSTART_G/FSTART_R registers become read/write).
module xgs_athena_lite #(
    parameter int LINES_PER_FRAME       = 8,
    parameter int MAX_PCIE_PAYLOAD_SIZE = 128,
    parameter int AXIL_ADDR_WIDTH       = 11
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset_n,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [7:0]                 irq,
    input  logic                       cfg_bus_mast_en,
    input  logic [2:0]                 cfg_setmaxpld,
    output logic                       tlp_req_to_send,
    input  logic                       tlp_grant,
    output logic [6:0]                 tlp_fmt_type,
    output logic [9:0]                 tlp_length_in_dw,
    output logic                       tlp_src_rdy_n,
    input  logic                       tlp_dst_rdy_n,
    output logic [63:0]                tlp_data,
    output logic [63:0]                tlp_address,
    output logic [7:0]                 tlp_ldwbe_fdwbe,
    output logic [1:0]                 tlp_attr,
    output logic [23:0]                tlp_transaction_id,
    output logic [12:0]                tlp_byte_count,
    output logic [6:0]                 tlp_lower_address
);

    localparam logic [AXIL_ADDR_WIDTH-1:0] A_TAG   = AXIL_ADDR_WIDTH'('h000);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_SCR   = AXIL_ADDR_WIDTH'('h00C);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_CTRL  = AXIL_ADDR_WIDTH'('h010);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_STAT  = AXIL_ADDR_WIDTH'('h014);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_FSL   = AXIL_ADDR_WIDTH'('h078);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_FSH   = AXIL_ADDR_WIDTH'('h07C);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_FGL   = AXIL_ADDR_WIDTH'('h080);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_FGH   = AXIL_ADDR_WIDTH'('h084);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_FRL   = AXIL_ADDR_WIDTH'('h088);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_FRH   = AXIL_ADDR_WIDTH'('h08C);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_PITCH = AXIL_ADDR_WIDTH'('h090);
    localparam logic [AXIL_ADDR_WIDTH-1:0] A_SIZE  = AXIL_ADDR_WIDTH'('h094);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_NEXT} dma_state_t;

    // ---------------- register file state ----------------
    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] scratch_q, fstart_lo_q, fstart_hi_q, pitch_q;
    logic [23:0] size_q;
    logic        irq_en_q, done_q;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
    logic [31:0] fg_lo_q, fg_hi_q, fr_lo_q, fr_hi_q;
`endif

    // ---------------- DMA state ----------------
    dma_state_t  state_q, state_d;
    logic [63:0] line_addr_q, line_addr_d;
    logic [31:0] pitch_l_q, pitch_l_d;
    logic [23:0] size_l_q, size_l_d;
    logic [23:0] off_q, off_d;
    logic [15:0] psize_q, psize_d;
    logic [9:0]  beats_q, beats_d;
    logic [31:0] line_q, line_d;
    logic [31:0] k_q, k_d;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
    logic [1:0]  plane_q, plane_d;
    logic [63:0] g_l_q, g_l_d, r_l_q, r_l_d;
`endif

    logic [AXIL_ADDR_WIDTH-1:0] waddr, raddr;
    logic        wr_fire, rd_fire, grab_req, start, done_clr, done_set, busy;
    logic [31:0] rd_mux, size_wr, cap;
    logic [15:0] psize_nx;
    logic [23:0] remain, burst_bytes, off_nx;
    logic [63:0] burst_addr;
    logic        unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    assign waddr    = {s_axi_awaddr[AXIL_ADDR_WIDTH-1:2], 2'b00};
    assign raddr    = {s_axi_araddr[AXIL_ADDR_WIDTH-1:2], 2'b00};
    assign wr_fire  = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire  = arready_q & s_axi_arvalid;
    assign busy     = (state_q != S_IDLE);
    assign grab_req = wr_fire && (waddr == A_CTRL) && s_axi_wstrb[0] && s_axi_wdata[0];
    assign start    = grab_req && cfg_bus_mast_en && !busy;
    assign done_clr = wr_fire && (waddr == A_STAT) && s_axi_wstrb[0] && s_axi_wdata[1];
    assign size_wr  = merge({8'h00, size_q}, s_axi_wdata, s_axi_wstrb);

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign irq           = {7'b0, done_q & irq_en_q};

    // Read-data mux over the register map; unmapped offsets return zero
    always_comb begin
        rd_mux = '0;
        case (raddr)
            A_TAG:   rd_mux = 32'h0058_544D;
            A_SCR:   rd_mux = scratch_q;
            A_CTRL:  rd_mux = {30'b0, irq_en_q, 1'b0};
            A_STAT:  rd_mux = {30'b0, done_q, busy};
            A_FSL:   rd_mux = fstart_lo_q;
            A_FSH:   rd_mux = fstart_hi_q;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
            A_FGL:   rd_mux = fg_lo_q;
            A_FGH:   rd_mux = fg_hi_q;
            A_FRL:   rd_mux = fr_lo_q;
            A_FRH:   rd_mux = fr_hi_q;
`endif
            A_PITCH: rd_mux = pitch_q;
            A_SIZE:  rd_mux = {8'h00, size_q};
            default: rd_mux = '0;
        endcase
    end

    // AXI-Lite handshakes, register writes and DONE flag maintenance
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            scratch_q   <= '0;
            fstart_lo_q <= '0;
            fstart_hi_q <= '0;
            pitch_q     <= '0;
            size_q      <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
            fg_lo_q     <= '0;
            fg_hi_q     <= '0;
            fr_lo_q     <= '0;
            fr_hi_q     <= '0;
`endif
        end else begin
            awready_q <= s_axi_awvalid & s_axi_wvalid & ~awready_q & ~bvalid_q;
            if (wr_fire)
                bvalid_q <= 1'b1;
            else if (s_axi_bready)
                bvalid_q <= 1'b0;

            arready_q <= s_axi_arvalid & ~arready_q & ~rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            if (wr_fire) begin
                case (waddr)
                    A_SCR:   scratch_q   <= merge(scratch_q, s_axi_wdata, s_axi_wstrb);
                    A_CTRL:  if (s_axi_wstrb[0]) irq_en_q <= s_axi_wdata[1];
                    A_FSL:   fstart_lo_q <= merge(fstart_lo_q, s_axi_wdata, s_axi_wstrb);
                    A_FSH:   fstart_hi_q <= merge(fstart_hi_q, s_axi_wdata, s_axi_wstrb);
`ifdef XGS_ATHENA_COLOR_PLANES_EN
                    A_FGL:   fg_lo_q     <= merge(fg_lo_q, s_axi_wdata, s_axi_wstrb);
                    A_FGH:   fg_hi_q     <= merge(fg_hi_q, s_axi_wdata, s_axi_wstrb);
                    A_FRL:   fr_lo_q     <= merge(fr_lo_q, s_axi_wdata, s_axi_wstrb);
                    A_FRH:   fr_hi_q     <= merge(fr_hi_q, s_axi_wdata, s_axi_wstrb);
`endif
                    A_PITCH: pitch_q     <= merge(pitch_q, s_axi_wdata, s_axi_wstrb);
                    A_SIZE:  size_q      <= {size_wr[23:3], 3'b000};
                    default: ;
                endcase
            end

            // completion wins over a same-cycle start/clear (zero-size grab)
            if (done_set)
                done_q <= 1'b1;
            else if (start || done_clr)
                done_q <= 1'b0;
        end
    end

    // Burst sizing: payload cap is the smaller of the negotiated and configured limits
    assign cap         = 32'd128 << cfg_setmaxpld;
    assign psize_nx    = (cap < 32'(MAX_PCIE_PAYLOAD_SIZE)) ? cap[15:0] : 16'(MAX_PCIE_PAYLOAD_SIZE);
    assign remain      = size_l_q - off_q;
    assign burst_bytes = (remain < 24'(psize_q)) ? remain : 24'(psize_q);
    assign burst_addr  = line_addr_q + 64'(off_q);
    assign off_nx      = off_q + burst_bytes;

    // DMA state and datapath registers
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            state_q     <= S_IDLE;
            line_addr_q <= '0;
            pitch_l_q   <= '0;
            size_l_q    <= '0;
            off_q       <= '0;
            psize_q     <= '0;
            beats_q     <= '0;
            line_q      <= '0;
            k_q         <= '0;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
            plane_q     <= '0;
            g_l_q       <= '0;
            r_l_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            pitch_l_q   <= pitch_l_d;
            size_l_q    <= size_l_d;
            off_q       <= off_d;
            psize_q     <= psize_d;
            beats_q     <= beats_d;
            line_q      <= line_d;
            k_q         <= k_d;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
            plane_q     <= plane_d;
            g_l_q       <= g_l_d;
            r_l_q       <= r_l_d;
`endif
        end
    end

    // DMA next-state: IDLE -> REQ -> DATA -> NEXT -> (REQ | IDLE)
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        pitch_l_d   = pitch_l_q;
        size_l_d    = size_l_q;
        off_d       = off_q;
        psize_d     = psize_q;
        beats_d     = beats_q;
        line_d      = line_q;
        k_d         = k_q;
        done_set    = 1'b0;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
        plane_d     = plane_q;
        g_l_d       = g_l_q;
        r_l_d       = r_l_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (size_q == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        line_addr_d = {fstart_hi_q, fstart_lo_q};
                        pitch_l_d   = pitch_q;
                        size_l_d    = size_q;
                        psize_d     = psize_nx;
                        off_d       = '0;
                        line_d      = '0;
                        k_d         = '0;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
                        plane_d     = '0;
                        g_l_d       = {fg_hi_q, fg_lo_q};
                        r_l_d       = {fr_hi_q, fr_lo_q};
`endif
                    end
                end
            end
            S_REQ: begin
                if (tlp_grant) begin
                    beats_d = burst_bytes[12:3];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!tlp_dst_rdy_n) begin
                    k_d     = k_q + 32'd1;
                    beats_d = beats_q - 10'd1;
                    if (beats_q == 10'd1)
                        state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (off_nx < size_l_q) begin
                    off_d   = off_nx;
                    state_d = S_REQ;
                end else begin
                    off_d = '0;
                    k_d   = '0;
                    if (line_q != 32'(LINES_PER_FRAME - 1)) begin
                        line_d      = line_q + 32'd1;
                        line_addr_d = line_addr_q + 64'(pitch_l_q);
                        state_d     = S_REQ;
                    end else begin
`ifdef XGS_ATHENA_COLOR_PLANES_EN
                        if (plane_q != 2'd2) begin
                            plane_d     = plane_q + 2'd1;
                            line_d      = '0;
                            line_addr_d = (plane_q == 2'd0) ? g_l_q : r_l_q;
                            state_d     = S_REQ;
                        end else begin
                            state_d  = S_IDLE;
                            done_set = 1'b1;
                        end
`else
                        state_d  = S_IDLE;
                        done_set = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tlp_req_to_send    = (state_q == S_REQ);
    assign tlp_src_rdy_n      = (state_q != S_DATA);
    assign tlp_address        = (state_q == S_REQ || state_q == S_DATA) ? burst_addr : '0;
    assign tlp_length_in_dw   = (state_q == S_REQ || state_q == S_DATA) ? burst_bytes[11:2] : '0;
    assign tlp_fmt_type       = (state_q == S_REQ || state_q == S_DATA) ?
                                ((burst_addr[63:32] != '0) ? 7'h60 : 7'h40) : 7'h00;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
    assign tlp_data           = (state_q == S_DATA) ? {plane_q, line_q[29:0], k_q} : '0;
`else
    assign tlp_data           = (state_q == S_DATA) ? {line_q, k_q} : '0;
`endif
    assign tlp_ldwbe_fdwbe    = 8'hFF;
    assign tlp_attr           = '0;
    assign tlp_transaction_id = '0;
    assign tlp_byte_count     = '0;
    assign tlp_lower_address  = '0;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         size_wr[31:24], size_wr[2:0], burst_bytes[23:13], burst_bytes[1:0]
`ifdef XGS_ATHENA_COLOR_PLANES_EN
                         , line_q[31:30]
`endif
                        };

endmodule

// File: tb/tb_xgs_athena_lite.sv
// Directed bench for xgs_athena_lite: register-access vector table plus
// hand-written DMA frame sequences checked against a bench-side address/data model.
module tb_xgs_athena_lite;

    localparam int LPF  = 8;
    localparam int PSZ  = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [7:0]  irq;
    logic        bus_en;
    logic [2:0]  maxpld;
    logic        req, grant, src_rdy_n, dst_rdy_n;
    logic [6:0]  fmt;
    logic [9:0]  len;
    logic [63:0] data, addr;
    logic [7:0]  be;
    logic [1:0]  attr;
    logic [23:0] tid;
    logic [12:0] bcnt;
    logic [6:0]  laddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xgs_athena_lite #(.LINES_PER_FRAME(LPF), .MAX_PCIE_PAYLOAD_SIZE(PSZ), .AXIL_ADDR_WIDTH(11)) dut (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .irq(irq), .cfg_bus_mast_en(bus_en), .cfg_setmaxpld(maxpld),
        .tlp_req_to_send(req), .tlp_grant(grant), .tlp_fmt_type(fmt), .tlp_length_in_dw(len),
        .tlp_src_rdy_n(src_rdy_n), .tlp_dst_rdy_n(dst_rdy_n), .tlp_data(data), .tlp_address(addr),
        .tlp_ldwbe_fdwbe(be), .tlp_attr(attr), .tlp_transaction_id(tid),
        .tlp_byte_count(bcnt), .tlp_lower_address(laddr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic axi_wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        chk("awready", {63'b0, awready}, 64'd1);
        chk("wready", {63'b0, wready}, 64'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        chk("bvalid", {63'b0, bvalid}, 64'd1);
        chk("bresp", {62'b0, bresp}, 64'd0);
    endtask

    task automatic axi_rd(input logic [10:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk("arready", {63'b0, arready}, 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        chk("rvalid", {63'b0, rvalid}, 64'd1);
        chk("rresp", {62'b0, rresp}, 64'd0);
        d = rdata;
    endtask

    task automatic rd_chk(input string name, input logic [10:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_rd(a, v);
        chk(name, {32'b0, v}, {32'b0, exp});
    endtask

    function automatic logic [63:0] exp_data(input int p, input int l, input int k);
        logic [63:0] r;
        r = {32'(l), 32'(k)};
`ifdef XGS_ATHENA_COLOR_PLANES_EN
        r[63:62] = 2'(p);
`endif
        return r;
    endfunction

    // Grants and drains every burst of a frame, checking header fields and beat data.
    task automatic run_frame(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2,
                             input logic [31:0] pitch, input int size, input bit rnd);
        int np, n, b, beats, k, bb;
        logic [63:0] base, ea;
`ifdef XGS_ATHENA_COLOR_PLANES_EN
        np = 3;
`else
        np = 1;
`endif
        for (int p = 0; p < np; p++) begin
            base = (p == 0) ? b0 : (p == 1) ? b1 : b2;
            for (int l = 0; l < LPF; l++) begin
                k = 0;
                for (int off = 0; off < size; off += PSZ) begin
                    bb = (size - off < PSZ) ? size - off : PSZ;
                    ea = base + 64'(l) * 64'(pitch) + 64'(off);
                    n = 0;
                    while (!req && n < 200) begin @(negedge clk); n++; end
                    chk("req", {63'b0, req}, 64'd1);
                    if (!req) return;
                    chk("tlp_address", addr, ea);
                    chk("tlp_fmt", {57'b0, fmt}, (ea[63:32] != 0) ? 64'h60 : 64'h40);
                    chk("tlp_len", {54'b0, len}, 64'(bb / 4));
                    grant = 1'b1;
                    @(negedge clk);
                    grant = 1'b0;
                    beats = bb / 8;
                    b = 0; n = 0;
                    while (b < beats && n < 2000) begin
                        dst_rdy_n = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                        #1;
                        if (!src_rdy_n) begin
                            chk("beat_data", data, exp_data(p, l, k));
                            if (!dst_rdy_n) begin b++; k++; end
                        end
                        @(negedge clk);
                        n++;
                    end
                    dst_rdy_n = 1'b1;
                    chk("beat_count", 64'(b), 64'(beats));
                    chk("src_rdy_n_after", {63'b0, src_rdy_n}, 64'd1);
                end
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];
    logic [31:0] exp80;
    int n;

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;
        arvalid = 1'b0; rready = 1'b1;
        bus_en = 1'b1; maxpld = 3'd0; grant = 1'b0; dst_rdy_n = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req", {63'b0, req}, 64'd0);
        chk("rst_src_rdy_n", {63'b0, src_rdy_n}, 64'd1);
        chk("rst_irq", {56'b0, irq}, 64'd0);
        chk("rst_bvalid", {63'b0, bvalid}, 64'd0);
        chk("rst_addr", addr, 64'd0);
        chk("rst_be", {56'b0, be}, 64'hFF);
        chk("rst_zero_fields", {18'b0, attr, tid, bcnt, laddr}, 64'd0);
        rst_n = 1'b1;

`ifdef XGS_ATHENA_COLOR_PLANES_EN
        exp80 = 32'h55AA55AA;
`else
        exp80 = 32'h0;
`endif
        // {write?, address, write data, strobes, expected read data}
        vt = '{
            '{0, 11'h000, 32'h0,        4'h0, 32'h0058544D},
            '{0, 11'h00C, 32'h0,        4'h0, 32'h0},
            '{1, 11'h00C, 32'hCAFEFADE, 4'hF, 32'hCAFEFADE},
            '{1, 11'h00C, 32'h00000011, 4'h1, 32'hCAFEFA11},
            '{1, 11'h094, 32'hFF12345F, 4'hF, 32'h00123458},
            '{1, 11'h094, 32'hAABBCCDD, 4'h2, 32'h0012CC58},
            '{1, 11'h090, 32'h00001234, 4'hF, 32'h00001234},
            '{1, 11'h080, 32'h55AA55AA, 4'hF, exp80},
            '{1, 11'h200, 32'hFFFFFFFF, 4'hF, 32'h0},
            '{1, 11'h000, 32'h00000001, 4'hF, 32'h0058544D},
            '{1, 11'h010, 32'h00000002, 4'h1, 32'h00000002},
            '{1, 11'h010, 32'h00000000, 4'h1, 32'h00000000},
            '{0, 11'h014, 32'h0,        4'h0, 32'h0}
        };
        foreach (vt[i]) begin
            if (vt[i].wr) axi_wr(vt[i].a, vt[i].d, vt[i].s);
            rd_chk($sformatf("reg_%03h_v%0d", vt[i].a, i), vt[i].a, vt[i].exp);
        end

        // Full frame, 3DW, with interrupt enabled
        axi_wr(11'h078, 32'hA0000000, 4'hF);
        axi_wr(11'h07C, 32'h0, 4'hF);
        axi_wr(11'h080, 32'hB0000000, 4'hF);
        axi_wr(11'h084, 32'h0, 4'hF);
        axi_wr(11'h088, 32'hC0000000, 4'hF);
        axi_wr(11'h08C, 32'h0, 4'hF);
        axi_wr(11'h090, 32'h1000, 4'hF);
        axi_wr(11'h094, 32'h1000, 4'hF);
        axi_wr(11'h010, 32'h3, 4'h1);
        rd_chk("status_busy", 11'h014, 32'h1);
        run_frame(64'hA0000000, 64'hB0000000, 64'hC0000000, 32'h1000, 32'h1000, 1'b0);
        rd_chk("status_done", 11'h014, 32'h2);
        chk("irq_done", {56'b0, irq}, 64'h01);
        axi_wr(11'h014, 32'h2, 4'h1);
        chk("irq_cleared", {56'b0, irq}, 64'h00);
        rd_chk("status_w1c", 11'h014, 32'h0);

        // 4DW addressing, IRQ disabled
        axi_wr(11'h07C, 32'h1, 4'hF);
        axi_wr(11'h084, 32'h2, 4'hF);
        axi_wr(11'h08C, 32'h3, 4'hF);
        axi_wr(11'h090, 32'h100, 4'hF);
        axi_wr(11'h094, 32'h100, 4'hF);
        axi_wr(11'h010, 32'h1, 4'h1);
        run_frame(64'h1_A0000000, 64'h2_B0000000, 64'h3_C0000000, 32'h100, 32'h100, 1'b0);
        rd_chk("status_done_4dw", 11'h014, 32'h2);
        chk("irq_masked", {56'b0, irq}, 64'h00);

        // Back-pressure plus a remainder burst (200 B = 128 + 72)
        maxpld = 3'd1;
        axi_wr(11'h078, 32'h00001000, 4'hF);
        axi_wr(11'h07C, 32'h0, 4'hF);
        axi_wr(11'h080, 32'h00002000, 4'hF);
        axi_wr(11'h084, 32'h0, 4'hF);
        axi_wr(11'h088, 32'h00003000, 4'hF);
        axi_wr(11'h08C, 32'h0, 4'hF);
        axi_wr(11'h090, 32'h400, 4'hF);
        axi_wr(11'h094, 32'hC8, 4'hF);
        axi_wr(11'h010, 32'h1, 4'h1);
        run_frame(64'h1000, 64'h2000, 64'h3000, 32'h400, 200, 1'b1);
        rd_chk("status_done_rnd", 11'h014, 32'h2);

        // Zero line size: done immediately, nothing requested
        axi_wr(11'h014, 32'h2, 4'h1);
        axi_wr(11'h094, 32'h0, 4'hF);
        axi_wr(11'h010, 32'h1, 4'h1);
        rd_chk("status_zero_size", 11'h014, 32'h2);
        chk("req_zero_size", {63'b0, req}, 64'd0);

        // Bus mastering disabled: start ignored
        axi_wr(11'h014, 32'h2, 4'h1);
        axi_wr(11'h094, 32'h100, 4'hF);
        bus_en = 1'b0;
        axi_wr(11'h010, 32'h1, 4'h1);
        rd_chk("status_no_master", 11'h014, 32'h0);
        repeat (5) @(negedge clk);
        chk("req_no_master", {63'b0, req}, 64'd0);
        bus_en = 1'b1;

        // Reset in the middle of a data burst
        axi_wr(11'h010, 32'h1, 4'h1);
        n = 0;
        while (!req && n < 50) begin @(negedge clk); n++; end
        chk("req_before_reset", {63'b0, req}, 64'd1);
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        dst_rdy_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("src_rdy_mid", {63'b0, src_rdy_n}, 64'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_src_rdy_n", {63'b0, src_rdy_n}, 64'd1);
        chk("rst_mid_req", {63'b0, req}, 64'd0);
        chk("rst_mid_data", data, 64'd0);
        chk("rst_mid_fmt", {57'b0, fmt}, 64'd0);
        rst_n = 1'b1;
        dst_rdy_n = 1'b1;
        rd_chk("status_after_rst", 11'h014, 32'h0);
        rd_chk("size_after_rst", 11'h094, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
